// File: rtl/udp_tx_mux_100g.sv
// Round-robin packet multiplexer: merges CHANNELS AXI-Stream UDP TX sources into one
// 100G output stream through a single output register, packets kept atomic.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | arbitration bubble; pick next requester from rr_ptr upward
// XFER  | granted channel streams beats until its tlast handshake
module udp_tx_mux_100g #(
   parameter int  CHANNELS   = 4,
   parameter int  DATA_WIDTH = 512,
   parameter int  KEEP_WIDTH = DATA_WIDTH / 8,
   localparam int ID_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           tx_axis_aclk,
   input  logic                           tx_axis_rst,
   input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [CHANNELS-1:0]            s_axis_tvalid,
   input  logic [CHANNELS-1:0]            s_axis_tlast,
   output logic [CHANNELS-1:0]            s_axis_tready,
   input  logic [CHANNELS-1:0]            channel_enable,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   output logic [ID_WIDTH-1:0]            m_axis_connection_id,
   input  logic                           m_axis_tready,
   output logic [31:0]                    pkt_count,
   output logic                           busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ID_WIDTH-1:0]   r_rr_ptr;
   logic [ID_WIDTH-1:0]   r_grant;
   logic [DATA_WIDTH-1:0] r_m_tdata;
   logic [KEEP_WIDTH-1:0] r_m_tkeep;
   logic                  r_m_tvalid;
   logic                  r_m_tlast;
   logic [ID_WIDTH-1:0]   r_m_id;
   logic [31:0]           r_pkt_count;

   logic [CHANNELS-1:0]   w_req;
   logic                  w_req_any;
   logic                  w_hi_found;
   logic [ID_WIDTH-1:0]   w_hi_idx;
   logic [ID_WIDTH-1:0]   w_any_idx;
   logic [ID_WIDTH-1:0]   w_arb_idx;
   logic [ID_WIDTH-1:0]   w_rr_next;
   logic                  w_out_ready;
   logic                  w_src_valid;
   logic                  w_src_last;
   logic [DATA_WIDTH-1:0] w_src_data;
   logic [KEEP_WIDTH-1:0] w_src_keep;
   logic                  w_src_hs;
   logic                  w_out_hs;

   assign w_req       = s_axis_tvalid & channel_enable;
   assign w_req_any   = |w_req;
   assign w_out_ready = !r_m_tvalid || m_axis_tready;
   assign w_out_hs    = r_m_tvalid && m_axis_tready;
   assign w_rr_next   = (r_grant == ID_WIDTH'(CHANNELS - 1)) ? '0 : r_grant + 1'b1;

   // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_any_idx  = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (w_req[c]) begin
            w_any_idx = ID_WIDTH'(c);
            if (ID_WIDTH'(c) >= r_rr_ptr) begin
               w_hi_found = 1'b1;
               w_hi_idx   = ID_WIDTH'(c);
            end
         end
      end
      w_arb_idx = w_hi_found ? w_hi_idx : w_any_idx;
   end

   always_comb begin
      w_src_valid = 1'b0;
      w_src_last  = 1'b0;
      w_src_data  = '0;
      w_src_keep  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (r_grant == ID_WIDTH'(c)) begin
            w_src_valid = s_axis_tvalid[c];
            w_src_last  = s_axis_tlast[c];
            w_src_data  = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
            w_src_keep  = s_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH];
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      s_axis_tready = '0;
      w_src_hs      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            for (int c = 0; c < CHANNELS; c++) begin
               if (r_grant == ID_WIDTH'(c)) begin
                  s_axis_tready[c] = w_out_ready;
               end
            end
            w_src_hs = w_src_valid && w_out_ready;
            if (w_src_hs && w_src_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge tx_axis_aclk) begin
      if (tx_axis_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge tx_axis_aclk) begin
      if (tx_axis_rst) begin
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_m_tdata   <= '0;
         r_m_tkeep   <= '0;
         r_m_tvalid  <= 1'b0;
         r_m_tlast   <= 1'b0;
         r_m_id      <= '0;
         r_pkt_count <= '0;
      end else begin
         if (r_state == ST_IDLE && w_req_any) begin
            r_grant <= w_arb_idx;
         end
         if (w_src_hs && w_src_last) begin
            r_rr_ptr <= w_rr_next;
         end
         // A load always wins over an output handshake so back-to-back beats stream.
         if (w_src_hs) begin
            r_m_tdata  <= w_src_data;
            r_m_tkeep  <= w_src_keep;
            r_m_tlast  <= w_src_last;
            r_m_id     <= r_grant;
            r_m_tvalid <= 1'b1;
         end else if (w_out_hs) begin
            r_m_tvalid <= 1'b0;
         end
         if (w_out_hs && r_m_tlast) begin
            r_pkt_count <= r_pkt_count + 32'd1;
         end
      end
   end

   assign m_axis_tdata         = r_m_tdata;
   assign m_axis_tkeep         = r_m_tkeep;
   assign m_axis_tvalid        = r_m_tvalid;
   assign m_axis_tlast         = r_m_tlast;
   assign m_axis_connection_id = r_m_id;
   assign pkt_count            = r_pkt_count;
   assign busy                 = (r_state == ST_XFER);

endmodule

// File: tb/tb_udp_tx_mux_100g.sv
// Self-checking bench for udp_tx_mux_100g: packet-level reference model plus a
// per-channel beat scoreboard, driven by directed phases and a randomized phase.
module tb_udp_tx_mux_100g;

   localparam int C  = 4;
   localparam int DW = 32;
   localparam int KW = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [C*DW-1:0] s_tdata;
   logic [C*KW-1:0] s_tkeep;
   logic [C-1:0]    s_tvalid;
   logic [C-1:0]    s_tlast;
   logic [C-1:0]    s_tready;
   logic [C-1:0]    en;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tvalid;
   logic            m_tlast;
   logic [IW-1:0]   m_id;
   logic            m_rdy;
   logic [31:0]     pkt_count;
   logic            busy;

   always #5 clk = ~clk;

   udp_tx_mux_100g #(
      .CHANNELS  (C),
      .DATA_WIDTH(DW),
      .KEEP_WIDTH(KW)
   ) dut (
      .tx_axis_aclk        (clk),
      .tx_axis_rst         (rst),
      .s_axis_tdata        (s_tdata),
      .s_axis_tkeep        (s_tkeep),
      .s_axis_tvalid       (s_tvalid),
      .s_axis_tlast        (s_tlast),
      .s_axis_tready       (s_tready),
      .channel_enable      (en),
      .m_axis_tdata        (m_tdata),
      .m_axis_tkeep        (m_tkeep),
      .m_axis_tvalid       (m_tvalid),
      .m_axis_tlast        (m_tlast),
      .m_axis_connection_id(m_id),
      .m_axis_tready       (m_rdy),
      .pkt_count           (pkt_count),
      .busy                (busy)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   beat_t src_q[C][$];
   beat_t exp_q[C][$];
   int    log_id[$];
   int    log_cyc[$];
   bit    log_last[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: who owns the output, where round-robin resumes, what sits in the register.
   bit          mdl_busy  = 1'b0;
   int          mdl_owner = 0;
   int          mdl_ptr   = 0;
   bit          mdl_ov    = 1'b0;
   beat_t       mdl_ob    = '0;
   int          mdl_oid   = 0;
   logic [31:0] mdl_pkt   = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t rnd_beat(input bit last);
      beat_t b;
      b.d = $urandom;
      b.k = ($urandom_range(0, 7) == 0) ? '0 : KW'($urandom);
      b.l = last;
      return b;
   endfunction

   task automatic push_pkt(input int c, input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b = rnd_beat(i == n - 1);
         src_q[c].push_back(b);
         exp_q[c].push_back(b);
      end
   endtask

   task automatic clear_all();
      for (int c = 0; c < C; c++) begin
         src_q[c].delete();
         exp_q[c].delete();
      end
      log_id.delete();
      log_cyc.delete();
      log_last.delete();
   endtask

   function automatic bit pending();
      bit p = mdl_busy || mdl_ov;
      for (int c = 0; c < C; c++) if (src_q[c].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drive();
      for (int c = 0; c < C; c++) begin
         if (src_q[c].size() > 0) begin
            s_tvalid[c]           = 1'b1;
            s_tdata[c*DW +: DW]   = src_q[c][0].d;
            s_tkeep[c*KW +: KW]   = src_q[c][0].k;
            s_tlast[c]            = src_q[c][0].l;
         end else begin
            s_tvalid[c]           = 1'b0;
            s_tdata[c*DW +: DW]   = '0;
            s_tkeep[c*KW +: KW]   = '0;
            s_tlast[c]            = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      mdl_busy  = 1'b0;
      mdl_owner = 0;
      mdl_ptr   = 0;
      mdl_ov    = 1'b0;
      mdl_ob    = '0;
      mdl_oid   = 0;
      mdl_pkt   = '0;
   endtask

   task automatic cycle();
      logic [C-1:0] exp_rdy;
      bit           src_hs;
      bit           out_hs;
      bit           found;
      beat_t        b;
      drive();
      #1;
      exp_rdy = '0;
      if (mdl_busy && (!mdl_ov || m_rdy)) exp_rdy[mdl_owner] = 1'b1;
      chk("s_tready", s_tready, exp_rdy);
      chk("m_tvalid", m_tvalid, mdl_ov);
      chk("busy", busy, mdl_busy);
      chk("pkt_count", pkt_count, mdl_pkt);
      if (mdl_ov) begin
         chk("m_tdata", m_tdata, mdl_ob.d);
         chk("m_tkeep", m_tkeep, mdl_ob.k);
         chk("m_tlast", m_tlast, mdl_ob.l);
         chk("m_id", m_id, mdl_oid);
      end
      if (!rst && m_tvalid === 1'b1 && m_rdy) begin
         log_id.push_back(int'(m_id));
         log_cyc.push_back(cyc);
         log_last.push_back(m_tlast);
         chk("sb_avail", exp_q[m_id].size() > 0, 1);
         if (exp_q[m_id].size() > 0) begin
            b = exp_q[m_id].pop_front();
            chk("sb_beat", {m_tdata, m_tkeep, m_tlast}, {b.d, b.k, b.l});
         end
      end
      if (rst) begin
         model_reset();
      end else begin
         out_hs = mdl_ov && m_rdy;
         src_hs = mdl_busy && s_tvalid[mdl_owner] && (!mdl_ov || m_rdy);
         if (out_hs && mdl_ob.l) mdl_pkt = mdl_pkt + 32'd1;
         if (!mdl_busy) begin
            found = 1'b0;
            for (int k = 0; k < C; k++) begin
               int c;
               c = (mdl_ptr + k) % C;
               if (!found && s_tvalid[c] && en[c]) begin
                  found     = 1'b1;
                  mdl_owner = c;
               end
            end
            if (found) mdl_busy = 1'b1;
         end
         if (src_hs) begin
            b       = src_q[mdl_owner].pop_front();
            mdl_ob  = b;
            mdl_oid = mdl_owner;
            mdl_ov  = 1'b1;
            if (b.l) begin
               mdl_busy = 1'b0;
               mdl_ptr  = (mdl_owner + 1) % C;
            end
         end else if (out_hs) begin
            mdl_ov = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input string tag, input int limit);
      int n = 0;
      while (pending() && n < limit) begin
         cycle();
         n++;
      end
      chk({tag, "_drained"}, pending(), 0);
   endtask

   task automatic check_reset_vals(input string p);
      chk({p, "_tvalid"}, m_tvalid, 0);
      chk({p, "_tlast"}, m_tlast, 0);
      chk({p, "_tdata"}, m_tdata, 0);
      chk({p, "_tkeep"}, m_tkeep, 0);
      chk({p, "_id"}, m_id, 0);
      chk({p, "_s_tready"}, s_tready, 0);
      chk({p, "_pkt_count"}, pkt_count, 0);
      chk({p, "_busy"}, busy, 0);
   endtask

   initial begin
      int          base;
      int          n;
      int          cnt2;
      logic [63:0] snap;

      // Power-on reset
      rst   = 1'b1;
      en    = '1;
      m_rdy = 1'b1;
      drive();
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      rst = 1'b0;
      model_reset();

      // Single 3-beat packet on channel 0
      clear_all();
      push_pkt(0, 3);
      base = cyc;
      drive();
      #1;
      chk("p1_rdy_c0", s_tready[0], 0);
      cycle();
      chk("p1_rdy_c1", s_tready[0], 1);
      drain("p1", 50);
      chk("p1_beats", log_id.size(), 3);
      if (log_id.size() == 3) begin
         chk("p1_latency", log_cyc[0] - base, 2);
         for (int i = 0; i < 3; i++) begin
            chk("p1_id", log_id[i], 0);
            chk("p1_last", log_last[i], (i == 2) ? 1 : 0);
         end
      end
      chk("p1_pkt_count", pkt_count, 1);

      // All channels saturated with 1-beat packets, pointer restarted by reset
      rst = 1'b1;
      cycle();
      check_reset_vals("p2_rst");
      rst = 1'b0;
      clear_all();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < C; c++) push_pkt(c, 1);
      base = cyc;
      drain("p2", 100);
      chk("p2_beats", log_id.size(), 8);
      if (log_id.size() == 8) begin
         chk("p2_first_lat", log_cyc[0] - base, 2);
         for (int i = 0; i < 8; i++) begin
            chk("p2_id", log_id[i], i % C);
            if (i > 0) chk("p2_bubble", log_cyc[i] - log_cyc[i-1], 2);
         end
      end

      // Output stall mid-packet
      clear_all();
      push_pkt(1, 6);
      repeat (4) cycle();
      m_rdy = 1'b0;
      snap  = {24'd0, m_tvalid, m_tlast, m_tdata, m_tkeep, m_id};
      chk("p3_stall_valid", m_tvalid, 1);
      repeat (5) begin
         cycle();
         chk("p3_hold", {24'd0, m_tvalid, m_tlast, m_tdata, m_tkeep, m_id}, snap);
         chk("p3_src_rdy", s_tready, 0);
      end
      m_rdy = 1'b1;
      drain("p3", 50);
      chk("p3_beats", log_id.size(), 6);
      for (int i = 0; i < log_id.size(); i++) chk("p3_id", log_id[i], 1);

      // Masked channel never granted
      clear_all();
      en = 4'b1011;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < C; c++) push_pkt(c, 2);
      n = 0;
      while ((src_q[0].size() > 0 || src_q[1].size() > 0 || src_q[3].size() > 0 ||
              mdl_busy || mdl_ov) && n < 200) begin
         cycle();
         n++;
      end
      chk("p4_mask_timeout", n < 200, 1);
      cnt2 = 0;
      foreach (log_id[i]) if (log_id[i] == 2) cnt2++;
      chk("p4_ch2_grants", cnt2, 0);
      chk("p4_beats", log_id.size(), 12);
      en = '1;
      drain("p4", 100);

      // Enable dropped mid-packet: packet still completes
      log_id.delete();
      log_cyc.delete();
      log_last.delete();
      push_pkt(0, 4);
      cycle();
      cycle();
      en[0] = 1'b0;
      drain("p5", 50);
      chk("p5_beats", log_id.size(), 4);
      if (log_id.size() == 4) begin
         chk("p5_last", log_last[3], 1);
         for (int i = 0; i < 4; i++) chk("p5_id", log_id[i], 0);
      end
      en = '1;

      // Randomized traffic with backpressure and mask changes
      for (int t = 0; t < 600; t++) begin
         if ($urandom_range(0, 3) == 0) push_pkt($urandom_range(0, C - 1), $urandom_range(1, 5));
         m_rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) en = C'($urandom_range(0, 15));
         cycle();
      end
      en    = '1;
      m_rdy = 1'b1;
      drain("p6", 2000);

      // Reset on beat 2 of a 4-beat packet
      clear_all();
      push_pkt(3, 4);
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      check_reset_vals("p7_rst");
      rst = 1'b0;
      clear_all();
      en = 4'b0110;
      push_pkt(0, 1);
      push_pkt(2, 1);
      push_pkt(1, 1);
      n = 0;
      while (log_id.size() == 0 && n < 20) begin
         cycle();
         n++;
      end
      chk("p7_grant_seen", log_id.size() > 0, 1);
      if (log_id.size() > 0) chk("p7_first_id", log_id[0], 1);
      en = '1;
      drain("p7", 50);

      // pkt_count wrap
      force dut.r_pkt_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_pkt_count;
      mdl_pkt = 32'hFFFF_FFFF;
      chk("p8_preset", pkt_count, 32'hFFFF_FFFF);
      push_pkt(2, 2);
      drain("p8", 50);
      chk("p8_wrap", pkt_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
